// File: rtl/instr_fetch_unit_pkg.sv
// rtl/instr_fetch_unit_pkg.sv - shared instruction constants and fetch FSM encodings
package instr_fetch_unit_pkg;

  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_J     = 6'd2;
  localparam logic [5:0] OP_BEQ   = 6'd4;
  localparam logic [5:0] OP_LW    = 6'd35;
  localparam logic [5:0] OP_SW    = 6'd43;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_VALID = 2'd2
  } fetch_state_t;

  // Word-scaled, sign-extended 16-bit branch displacement.
  function automatic logic [31:0] branch_offset(input logic [15:0] imm);
    return {{14{imm[15]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/pc_next_logic.sv
// rtl/pc_next_logic.sv - next-PC selection: jump over taken branch over sequential
module pc_next_logic
  import instr_fetch_unit_pkg::*;
(
  input  logic [31:0] PCPlus4,
  input  logic [25:0] Instr,
  input  logic        Jump,
  input  logic        Branch,
  input  logic        Zero,
  output logic [31:0] PCNext
);

  logic [31:0] jump_target;
  logic [31:0] branch_target;

  assign jump_target   = {PCPlus4[31:28], Instr, 2'b00};
  assign branch_target = PCPlus4 + branch_offset(Instr[15:0]);

  always_comb begin
    PCNext = PCPlus4;
    if (Jump) begin
      PCNext = jump_target;
    end else if (Branch && Zero) begin
      PCNext = branch_target;
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - instruction fetch: req/ack memory handshake, PC ownership,
// and a held instruction slot released by the decode/execute stage.
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        Clk,
  input  logic        Reset,
  output logic        IMemReq,
  output logic [31:0] IMemAddr,
  input  logic        IMemAck,
  input  logic [31:0] IMemRData,
  output logic [31:0] Instr,
  output logic [5:0]  Op,
  output logic [5:0]  Funct,
  output logic        InstrValid,
  input  logic        InstrTaken,
  input  logic        Jump,
  input  logic        Branch,
  input  logic        Zero,
  output logic [31:0] PC,
  output logic [31:0] PCPlus4,
  output logic [31:0] FetchCount
);

  fetch_state_t state;
  fetch_state_t state_next;
  logic         load_instr;
  logic         advance_pc;
  logic [31:0]  pc_next;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    load_instr = 1'b0;
    advance_pc = 1'b0;
    case (state)
      ST_IDLE: begin
        state_next = ST_FETCH;
      end
      ST_FETCH: begin
        if (IMemAck) begin
          load_instr = 1'b1;
          state_next = ST_VALID;
        end
      end
      ST_VALID: begin
        if (InstrTaken) begin
          advance_pc = 1'b1;
          state_next = ST_FETCH;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  pc_next_logic u_pc_next_logic (
    .PCPlus4 (PCPlus4),
    .Instr   (Instr[25:0]),
    .Jump    (Jump),
    .Branch  (Branch),
    .Zero    (Zero),
    .PCNext  (pc_next)
  );

  // Instr, PC and FetchCount only move on handshake edges, keeping them stable through VALID.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      PC         <= RESET_PC;
      Instr      <= '0;
      FetchCount <= '0;
    end else begin
      if (load_instr) begin
        Instr <= IMemRData;
      end
      if (advance_pc) begin
        PC         <= pc_next;
        FetchCount <= FetchCount + 32'd1;
      end
    end
  end

  assign PCPlus4    = PC + 32'd4;
  assign IMemAddr   = PC;
  assign IMemReq    = (state == ST_FETCH);
  assign InstrValid = (state == ST_VALID);
  assign Op         = Instr[31:26];
  assign Funct      = Instr[5:0];

endmodule
